// File: rtl/mprj_checkpoint_monitor.sv
// mprj_checkpoint_monitor: ordered checkpoint-sequence monitor with timeout and strict-order checks
module mprj_checkpoint_monitor #(
  parameter int CHK_W = 16,
  parameter int DEPTH = 8,
  parameter int TO_W = 24,
  parameter int STABLE = 2,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [CHK_W-1:0] cfg_data,
  input  logic [IDX_W:0]   cfg_num,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             cfg_strict,
  input  logic             start,
  input  logic             abort,
  input  logic [CHK_W-1:0] chk_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail_timeout,
  output logic             fail_mismatch,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output logic [IDX_W:0]   progress,
  output logic [TO_W-1:0]  elapsed
);
  localparam int ST_W = $clog2(STABLE + 2);
  localparam logic [IDX_W:0] DEPTH_N = (IDX_W + 1)'(DEPTH);
  localparam logic [ST_W-1:0] STABLE_N = ST_W'(STABLE);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;
  state_t state_q, state_d;
  logic [CHK_W-1:0] s1_q, s2_q, prev_q;
  logic [ST_W-1:0] run_q, run_d, held;
  logic [CHK_W-1:0] tbl_q [DEPTH];
  logic [CHK_W-1:0] tbl_d [DEPTH];
  logic [TO_W-1:0] timer_q, timer_d, elapsed_q, elapsed_d;
  logic [IDX_W:0] progress_q, progress_d;
  logic [IDX_W-1:0] hit_idx_q, hit_idx_d, cur_idx, prv_idx;
  logic hit_q, hit_d, fto_q, fto_d, fmm_q, fmm_d;
  logic qual, go, clr, match, last, mism, tmo;
  // two-flop synchronizer plus a one-cycle delayed copy for change detection
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
      prev_q <= '0;
    end else begin
      s1_q <= chk_in;
      s2_q <= s1_q;
      prev_q <= s2_q;
    end
  end
  // held counts the cycles the synchronized value has lasted; qualify fires once when it reaches STABLE
  always_comb begin
    held = (s2_q == prev_q) ? run_q + 1'b1 : ST_W'(1);
    qual = held == STABLE_N;
    run_d = go ? '0 : (held > STABLE_N ? STABLE_N : held);
  end
  // run events: accepted start, entry match, strict mismatch and timer expiry
  always_comb begin
    cur_idx = progress_q[IDX_W-1:0];
    prv_idx = cur_idx - 1'b1;
    go = start && state_q != S_RUN && |cfg_num && cfg_num <= DEPTH_N;
    clr = abort || go;
    match = state_q == S_RUN && qual && s2_q == tbl_q[cur_idx];
    last = progress_q + 1'b1 == cfg_num;
    mism = state_q == S_RUN && cfg_strict && |progress_q && qual &&
           s2_q != tbl_q[cur_idx] && s2_q != tbl_q[prv_idx];
    tmo = state_q == S_RUN && |cfg_timeout && timer_q + 1'b1 == cfg_timeout;
  end
  // state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  // next state: abort first, then start, then hit beats mismatch/timeout
  always_comb begin
    state_d = abort ? S_IDLE :
              go ? S_RUN :
              state_q != S_RUN ? state_q :
              match ? (last ? S_PASS : S_RUN) :
              (mism || tmo) ? S_FAIL : S_RUN;
  end
  // counters and status for the next cycle
  always_comb begin
    timer_d = clr ? '0 : state_q == S_RUN ? (match ? '0 : timer_q + 1'b1) : timer_q;
    elapsed_d = clr ? '0 : (state_q == S_RUN && !(&elapsed_q)) ? elapsed_q + 1'b1 : elapsed_q;
    progress_d = clr ? '0 : match ? progress_q + 1'b1 : progress_q;
    hit_idx_d = clr ? '0 : match ? cur_idx : hit_idx_q;
    hit_d = match && !abort;
    fto_d = clr ? 1'b0 : fto_q | (tmo && !match && !mism);
    fmm_d = clr ? 1'b0 : fmm_q | mism;
  end
  // expected-value table is frozen while a run is active
  always_comb begin
    tbl_d = tbl_q;
    if (cfg_we && state_q != S_RUN) tbl_d[cfg_idx] = cfg_data;
  end
  // datapath registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      run_q <= '0;
      tbl_q <= '{default: '0};
      timer_q <= '0;
      elapsed_q <= '0;
      progress_q <= '0;
      hit_idx_q <= '0;
      hit_q <= 1'b0;
      fto_q <= 1'b0;
      fmm_q <= 1'b0;
    end else begin
      run_q <= run_d;
      tbl_q <= tbl_d;
      timer_q <= timer_d;
      elapsed_q <= elapsed_d;
      progress_q <= progress_d;
      hit_idx_q <= hit_idx_d;
      hit_q <= hit_d;
      fto_q <= fto_d;
      fmm_q <= fmm_d;
    end
  end
  assign busy = state_q == S_RUN;
  assign done = state_q == S_PASS || state_q == S_FAIL;
  assign pass = state_q == S_PASS;
  assign fail_timeout = fto_q;
  assign fail_mismatch = fmm_q;
  assign hit = hit_q;
  assign hit_idx = hit_idx_q;
  assign progress = progress_q;
  assign elapsed = elapsed_q;
endmodule
